bitwise_logic_unit: RTL

Parametrised, registered successor to the fixed 32-bit XOR block. Computes one of eight bitwise operations on two WIDTH-bit operands. Includes an internal XOR accumulator for running checksums. Uses valid/ready handshakes on input and output. Sits in the MiniMIPS execute stage beside the adder/shifter and also serves as a standalone checksum engine.

---
 rtl/bitwise_logic_pkg.sv | 15 +
 rtl/bitwise_logic_unit_logic_slice.sv | 39 +++
 rtl/bitwise_logic_unit.sv | 107 ++++++++++
 3 files changed

// File: rtl/bitwise_logic_pkg.sv
// rtl/bitwise_logic_pkg.sv - op encodings and op type for bitwise_logic_unit
package bitwise_logic_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_AND     = 3'b000;
    localparam op_t OP_OR      = 3'b001;
    localparam op_t OP_XOR     = 3'b010;
    localparam op_t OP_NOR     = 3'b011;
    localparam op_t OP_XNOR    = 3'b100;
    localparam op_t OP_ANDN    = 3'b101;
    localparam op_t OP_ACC_XOR = 3'b110;
    localparam op_t OP_ACC_CLR = 3'b111;

endpackage

// File: rtl/bitwise_logic_unit_logic_slice.sv
// rtl/bitwise_logic_unit_logic_slice.sv - combinational function unit (result and next accumulator)
module logic_slice
    import bitwise_logic_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] acc_next
);

    always_comb begin
        result   = '0;
        acc_next = acc;
        case (op)
            OP_AND:     result = A & B;
            OP_OR:      result = A | B;
            OP_XOR:     result = A ^ B;
            OP_NOR:     result = ~(A | B);
            OP_XNOR:    result = ~(A ^ B);
            OP_ANDN:    result = A & ~B;
            OP_ACC_XOR: begin
                acc_next = acc ^ A ^ B;
                result   = acc ^ A ^ B;
            end
            // Clear reports the value being discarded so a checksum can be read and reset in one op.
            OP_ACC_CLR: begin
                result   = acc;
                acc_next = ACC_INIT;
            end
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_logic_unit.sv
// rtl/bitwise_logic_unit.sv - registered bitwise unit with XOR accumulator; BITWISE_LOGIC_PARITY_EN adds a parity output
module bitwise_logic_unit
    import bitwise_logic_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] R,
    output logic             zero,
    output logic [WIDTH-1:0] acc
`ifdef BITWISE_LOGIC_PARITY_EN
    ,
    output logic             parity
`endif
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] slice_result;
    logic [WIDTH-1:0] slice_acc_next;
    logic             accept;
    logic             consume;

    logic_slice #(
        .WIDTH    (WIDTH),
        .ACC_INIT (ACC_INIT)
    ) u_slice (
        .op       (op),
        .A        (A),
        .B        (B),
        .acc      (acc_q),
        .result   (slice_result),
        .acc_next (slice_acc_next)
    );

    // Single output register: a slot frees up in the same cycle the consumer takes it.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid_q && out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        r_d         = r_q;
        zero_d      = zero_q;
        acc_d       = acc_q;
        if (accept) begin
            out_valid_d = 1'b1;
            r_d         = slice_result;
            zero_d      = ~|slice_result;
            acc_d       = slice_acc_next;
        end else if (consume) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            r_q         <= '0;
            zero_q      <= 1'b1;
            acc_q       <= ACC_INIT;
        end else begin
            out_valid_q <= out_valid_d;
            r_q         <= r_d;
            zero_q      <= zero_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign R         = r_q;
    assign zero      = zero_q;
    assign acc       = acc_q;

`ifdef BITWISE_LOGIC_PARITY_EN
    logic parity_q, parity_d;

    always_comb begin
        parity_d = parity_q;
        if (accept) begin
            parity_d = ^slice_result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity = parity_q;
`endif

endmodule
